// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage: fetch FSM states and the
// prefetch queue entry layout.
package if_pkg;
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0;

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] inst;
  } if_entry_t;
endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/ready handshake between the fetch sequencer
// (master) and the instruction memory (slave).
interface fetch_sequencer_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] data;

  modport master (output req, output addr, input ready, input data);
  modport slave  (input req, input addr, output ready, output data);
endinterface

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of QDEPTH entries; flush has priority over
// push/pop, and push+pop on a full queue keeps the entry count.
module fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  if_entry_t din,
  output logic      full,
  output logic      empty,
  output if_entry_t head
);
  localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  if_entry_t       mem [QDEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(QDEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage fetch controller: owns the PC, runs the imem request/ready
// handshake and feeds the IF/ID register from a prefetch queue.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module fetch_sequencer
  import if_pkg::*;
#(
  parameter int unsigned QDEPTH   = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  fetch_sequencer_if.master         imem,
  input  logic                      freeze,
  input  logic                      branch_taken,
  input  logic [31:0]               branch_addr,
  output logic                      if_valid,
  output logic [31:0]               if_inst,
  output logic [31:0]               if_pc,
  output logic [31:0]               fetch_cnt,
  output logic [31:0]               bubble_cnt
);
  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [31:0]  held_addr;
  logic [31:0]  br_target;
  logic         q_full;
  logic         q_empty;
  if_entry_t    q_head;
  if_entry_t    q_din;
  logic         done;
  logic         push;
  logic         pop;

  assign br_target = branch_addr & ~32'h3;

  // Request is decoded from state and queue occupancy only, never from ready.
  assign imem.req  = ~rst & ((state != ISSUE) | ~q_full);
  assign imem.addr = (state == DISCARD) ? held_addr : fetch_pc;

  assign done  = imem.req & imem.ready;
  assign push  = done & (state != DISCARD) & ~branch_taken;
  assign pop   = ~q_empty & ~freeze & ~branch_taken;
  assign q_din = '{pc_plus4: fetch_pc + 32'd4, inst: imem.data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ISSUE;
      fetch_pc  <= RESET_PC;
      held_addr <= RESET_PC;
    end else begin
      // Remember the presented address so a redirect can keep it on the bus.
      if (state != DISCARD) held_addr <= fetch_pc;
      if (branch_taken) begin
        fetch_pc <= br_target;
        state    <= (imem.req && !imem.ready) ? DISCARD : ISSUE;
      end else if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        state    <= ISSUE;
      end else if (done) begin
        state    <= ISSUE;
      end else if (imem.req && state == ISSUE) begin
        state    <= WAIT;
      end
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (branch_taken),
    .din   (q_din),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
  );

  assign if_valid = ~q_empty;
  assign if_inst  = q_empty ? NOP_INST : q_head.inst;
  assign if_pc    = q_empty ? 32'h0 : q_head.pc_plus4;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (push)               fetch_cnt  <= fetch_cnt + 32'd1;
      if (q_empty && !freeze) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`else
  assign fetch_cnt  = '0;
  assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, corner sequences and
// randomized traffic checked against a queue-based model of the fetch rules.
module tb_fetch_sequencer;
  import if_pkg::*;

  localparam int unsigned QDEPTH   = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken;
  logic [31:0] branch_addr;
  logic        if_valid;
  logic [31:0] if_inst, if_pc, fetch_cnt, bubble_cnt;

  always #5 clk = ~clk;

  fetch_sequencer_if imem ();

  fetch_sequencer #(.QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .imem(imem), .freeze(freeze),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of fetched words, a fetch PC and at most one
  // pending request that may be marked for discard.
  if_entry_t   mq[$];
  logic [31:0] m_pc, m_pa, m_fetch, m_bub;
  bit          m_pv, m_pd, m_known = 0;

  function automatic bit m_req(input logic r);
    return !r && (m_pv || mq.size() < QDEPTH);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_pv ? m_pa : m_pc;
  endfunction

  task automatic m_step(input logic r, f, b, input logic [31:0] ba,
                        input logic rdy, input logic [31:0] d);
    bit req, valid;
    logic [31:0] a;
    if (r) begin
      mq.delete(); m_pc = RESET_PC; m_pv = 0; m_pd = 0;
      m_fetch = 0; m_bub = 0; m_known = 1;
      return;
    end
    req = m_req(1'b0); valid = mq.size() > 0; a = m_addr();
    if (!valid && !f) m_bub++;
    if (b) begin
      mq.delete();
      m_pc = ba & ~32'h3;
      if (req && !rdy) begin m_pa = a; m_pv = 1; m_pd = 1; end
      else m_pv = 0;
    end else begin
      if (valid && !f) void'(mq.pop_front());
      if (req && rdy) begin
        if (!(m_pv && m_pd)) begin
          mq.push_back('{pc_plus4: a + 32'd4, inst: d});
          m_fetch++;
          m_pc = a + 32'd4;
        end
        m_pv = 0;
      end else if (req) begin
        if (!m_pv) m_pd = 0;
        m_pa = a; m_pv = 1;
      end
    end
  endtask

  // Memory environment: fixed latency or random ready.
  int mem_lat = 0;
  bit mem_rand = 0;
  int mem_cnt = 0;

  task automatic cyc(input logic r, f, b, input logic [31:0] ba);
    logic [31:0] e_fc, e_bc;
    @(negedge clk);
    rst = r; freeze = f; branch_taken = b; branch_addr = ba;
    #1;
    if (imem.req) imem.ready = mem_rand ? ($urandom_range(0, 2) == 0) : (mem_cnt >= mem_lat);
    else          imem.ready = 1'b0;
    imem.data = mem_rand ? $urandom : (imem.addr >> 2);
    mem_cnt = (imem.req && !imem.ready) ? mem_cnt + 1 : 0;
    #1;
    if (m_known) begin
`ifdef IF_PERF_CNT_EN
      e_fc = m_fetch; e_bc = m_bub;
`else
      e_fc = 32'h0; e_bc = 32'h0;
`endif
      chk("req", 32'(imem.req), 32'(m_req(r)));
      if (m_req(r)) chk("addr", imem.addr, m_addr());
      chk("valid", 32'(if_valid), 32'(mq.size() > 0));
      chk("inst", if_inst, (mq.size() > 0) ? mq[0].inst : NOP_INST);
      chk("pc", if_pc, (mq.size() > 0) ? mq[0].pc_plus4 : 32'h0);
      chk("fetch_cnt", fetch_cnt, e_fc);
      chk("bubble_cnt", bubble_cnt, e_bc);
    end
    m_step(r, f, b, ba, imem.ready, imem.data);
  endtask

  typedef struct {
    logic        r, f, exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc, exp_inst;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int cnt8, found;
    logic [31:0] b0;
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    imem.ready = 1'b0; imem.data = '0;

    // Zero-wait start-up and a 5-cycle freeze with QDEPTH=2.
    tbl[0]  = '{1, 0, 0, 32'd0,  0, 32'd0,  32'd0};
    tbl[1]  = '{0, 0, 1, 32'd0,  0, 32'd0,  32'd0};
    tbl[2]  = '{0, 0, 1, 32'd4,  1, 32'd4,  32'd0};
    tbl[3]  = '{0, 0, 1, 32'd8,  1, 32'd8,  32'd1};
    tbl[4]  = '{0, 1, 1, 32'd12, 1, 32'd12, 32'd2};
    tbl[5]  = '{0, 1, 0, 32'd0,  1, 32'd12, 32'd2};
    tbl[6]  = '{0, 1, 0, 32'd0,  1, 32'd12, 32'd2};
    tbl[7]  = '{0, 1, 0, 32'd0,  1, 32'd12, 32'd2};
    tbl[8]  = '{0, 1, 0, 32'd0,  1, 32'd12, 32'd2};
    tbl[9]  = '{0, 0, 0, 32'd0,  1, 32'd12, 32'd2};
    tbl[10] = '{0, 0, 1, 32'd16, 1, 32'd16, 32'd3};
    tbl[11] = '{0, 0, 1, 32'd20, 1, 32'd20, 32'd4};

    cyc(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].r, tbl[i].f, 0, 0);
      chk($sformatf("tbl%0d_req", i), 32'(imem.req), 32'(tbl[i].exp_req));
      if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), imem.addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_pc", i), if_pc, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_inst", i), if_inst, tbl[i].exp_inst);
    end

    // Three wait cycles: address 8 held four cycles, three bubbles per fetch.
    mem_lat = 3;
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    cnt8 = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(0, 0, 0, 0);
      if (imem.req && imem.addr == 32'h8) cnt8++;
    end
    chk("lat3_addr8_cycles", 32'(cnt8), 32'd4);
    b0 = bubble_cnt;
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
`ifdef IF_PERF_CNT_EN
    chk("lat3_bubbles", bubble_cnt - b0, 32'd6);
`else
    chk("lat3_bubbles", bubble_cnt - b0, 32'd0);
`endif

    // Redirect while a request waits: old data discarded, target 0x100.
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(0, 0, 0, 0);
      if (mem_cnt == 1) found = 1;
    end
    chk("wait_reached", 32'(found), 32'd1);
    cyc(0, 0, 1, 32'h103);
    cyc(0, 0, 0, 0);
    chk("br_valid_low", 32'(if_valid), 32'd0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem.req && imem.addr == 32'h100) found = 1;
      else cyc(0, 0, 0, 0);
    end
    chk("br_target_req", 32'(found), 32'd1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(0, 0, 0, 0);
      if (if_valid) found = 1;
    end
    chk("br_first_valid", 32'(found), 32'd1);
    chk("br_first_pc", if_pc, 32'h104);

    // Branch, freeze and ready together: returned word dropped.
    mem_lat = 0;
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 32'h200);
    cyc(0, 0, 0, 0);
    chk("bfr_empty", 32'(if_valid), 32'd0);
    chk("bfr_req", 32'(imem.req), 32'd1);
    chk("bfr_addr", imem.addr, 32'h200);
    cyc(0, 0, 0, 0);
    chk("bfr_pc", if_pc, 32'h204);
    chk("bfr_inst", if_inst, 32'h80);

    // Reset during WAIT.
    mem_lat = 3;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(0, 0, 0, 0);
      if (mem_cnt == 1) found = 1;
    end
    chk("rst_wait_reached", 32'(found), 32'd1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_req", 32'(imem.req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_bubble_cnt", bubble_cnt, 32'd0);
    cyc(0, 0, 0, 0);
    chk("rst_restart_req", 32'(imem.req), 32'd1);
    chk("rst_restart_addr", imem.addr, RESET_PC);

    // Randomized traffic against the model.
    mem_rand = 1;
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 15) == 0), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the MIPS pipeline IF stage. It owns the PC and issues word-aligned read requests to the instruction memory through a request/ready handshake, so the same block works with a zero-wait ROM or a multi-cycle SRAM. Fetched words are buffered in a small prefetch queue and presented to the IF/ID register. The block honours ID-stage freeze and redirects on taken branches, discarding any in-flight fetch.

## Interface
Parameters:
- QDEPTH, 2: prefetch queue entries (power of two, ≥2)
- RESET_PC, 32'h0: PC after reset

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  byte address of request, bits [1:0] always 0
- imem_ready  in  1  memory has returned data for the current request, valid the same cycle
- imem_data  in  32  instruction word, sampled when imem_req & imem_ready
- freeze  in  1  IF/ID hold; the queue head is not consumed
- branch_taken  in  1  redirect request from the branch unit
- branch_addr  in  32  redirect target; bits [1:0] ignored and forced to 0
- if_valid  out  1  queue head is valid
- if_inst  out  32  head instruction; 32'h0 (NOP) when !if_valid
- if_pc  out  32  head PC + 4; 0 when !if_valid
- fetch_cnt  out  32  completed fetches (see Configuration)
- bubble_cnt  out  32  cycles with !if_valid & !freeze (see Configuration)

## Operation
- FSM states:
  - ISSUE: request when the queue has a free slot, counting the outstanding request.
  - WAIT: request outstanding.
  - DISCARD: a redirect arrived while a request was outstanding; wait for ready and drop the data.
- Transitions:
  - ISSUE→WAIT on imem_req & !imem_ready.
  - ISSUE stays in ISSUE on imem_req & imem_ready. Data is enqueued, fetch_pc advances by 4, and a new request may issue the next cycle.
  - WAIT→ISSUE on imem_ready, with enqueue and fetch_pc += 4.
  - WAIT→DISCARD on branch_taken & !imem_ready.
  - DISCARD→ISSUE on imem_ready, with no enqueue.
- Pop: the head is consumed at the clock edge when if_valid & !freeze & !branch_taken.
- Redirect, on branch_taken:
  - Flush the queue.
  - fetch_pc ← {branch_addr[31:2],2'b00}.
  - Data returning the same cycle is dropped.
  - Branch wins over freeze, pop and enqueue.
  - If the memory completes in the redirect cycle, the FSM goes to ISSUE, not DISCARD.
- Enqueue and pop may occur in the same cycle when the queue is full. The entry count is unchanged.
- Only one request is outstanding at any time. The PC wraps modulo 2^32 with no error.
- Reset mid-fetch: the outstanding request is abandoned. The memory must tolerate imem_req dropping without ready.

## Timing
- Reset values:
  - fetch_pc = RESET_PC, FSM = ISSUE, queue empty.
  - imem_req = 0 while rst is high; it asserts in the first cycle after rst deasserts, with imem_addr = RESET_PC.
  - if_valid = 0, if_inst = 0, if_pc = 0, counters = 0.
- Handshake: once imem_req is high, imem_req and imem_addr hold stable until imem_ready. The only exits are branch_taken, which moves to DISCARD with imem_req still high at the old address, or rst.
- imem_req is a registered or FSM-decoded output. It must not depend combinationally on imem_ready.
- Latency with a zero-wait memory:
  - Request in cycle n; if_valid from cycle n+1.
  - Sustained throughput is one instruction per cycle.
- After branch_taken in cycle n:
  - A request to the target issues in cycle n+1 if nothing was outstanding, otherwise after the discarded ready.
  - if_valid = 0 from cycle n+1 until the target's data is enqueued.
- With memory latency L wait cycles, each fetch takes L+1 cycles.

## Configuration
- IF_PERF_CNT_EN defined:
  - fetch_cnt increments on every enqueue.
  - bubble_cnt increments on each cycle with !if_valid & !freeze.
  - Both are 32-bit, wrap, and clear on rst.
- IF_PERF_CNT_EN undefined: the counter logic is removed and both ports are tied to 0.

## Structure
- Shared package if_pkg holds:
  - NOP_INST = 32'h0
  - fetch FSM state enum {ISSUE, WAIT, DISCARD}
  - queue entry struct {pc_plus4[31:0], inst[31:0]}
- Sub-module fetch_queue: synchronous FIFO of QDEPTH entries.
  - Ports: push, pop, flush, full, empty, head.
  - Priority is flush > push/pop.
  - Simultaneous push and pop is allowed when full.

## Test plan
- Zero-wait memory returning inst[i] = i, freeze = 0: after reset, imem_addr steps 0,4,8,… every cycle. if_valid goes high in cycle 2 after rst falls, with if_pc = 4.
- Memory with 3 wait cycles: imem_addr = 0x8 held 4 cycles. bubble_cnt increases by 3 per fetch with the macro defined, and stays 0 without it.
- freeze held 5 cycles with QDEPTH = 2: the queue fills, imem_req drops after 2 entries, and if_inst stays constant. On release, the stream resumes with no loss or duplication.
- branch_taken with branch_addr = 0x103 while a request is in WAIT: the old data is discarded on ready. The next imem_addr is 0x100, and the first valid if_pc is 0x104.
- branch_taken, freeze and imem_ready all high in one cycle: the queue is empty next cycle. The returned word never appears, and the next request goes to the target.
- rst asserted during WAIT: next cycle imem_req = 0, if_valid = 0, and all counters = 0. After release, the fetch restarts at RESET_PC.
